// File: rtl/dcache_mshr_ctrl_pkg.sv
// Shared types and sizing for the data-cache / MSHR controller.
// Holds the memory command encoding and the MSHR entry layout.
package dcache_mshr_ctrl_pkg;

  localparam int unsigned NUM_LINES  = 32;
  localparam int unsigned MSHR_NUM   = 4;
  localparam int unsigned MEM_TAG_W  = 4;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned IDX_W      = $clog2(NUM_LINES);
  localparam int unsigned TAG_W      = ADDR_W - 3 - IDX_W;
  localparam int unsigned MSHR_IDX_W = $clog2(MSHR_NUM);

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_cmd_e;

  typedef struct packed {
    logic                 busy;
    logic [ADDR_W-1:0]    addr;
    logic [MEM_TAG_W-1:0] tag;
  } mshr_entry_t;

endpackage

// File: rtl/dcache_mshr_ctrl_mshr_file.sv
// Miss status holding registers: lowest-free allocation, address CAM for
// load merge / store blocking, tag CAM for fill matching.
module dcache_mshr_ctrl_mshr_file
  import dcache_mshr_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MEM_TAG_W-1:0] i_fill_tag,
  input  logic [ADDR_W-1:0]    i_ld_addr,
  input  logic [ADDR_W-1:0]    i_st_addr,
  input  logic                 i_alloc,
  input  logic [ADDR_W-1:0]    i_alloc_addr,
  input  logic [MEM_TAG_W-1:0] i_alloc_tag,
  output logic                 o_fill_vld,
  output logic [ADDR_W-1:0]    o_fill_addr,
  output logic                 o_ld_match,
  output logic                 o_st_match,
  output logic                 o_full
);

  mshr_entry_t r_entries [MSHR_NUM];

  logic [MSHR_NUM-1:0]   w_fill_hit;
  logic [MSHR_NUM-1:0]   w_free;
  logic [MSHR_IDX_W-1:0] w_alloc_idx;

  // Entry being filled this cycle is excluded from the address CAM: it is
  // already resolved, so merging into it would miss the broadcast.
  always_comb begin
    w_fill_hit  = '0;
    w_free      = '0;
    w_alloc_idx = '0;
    o_fill_addr = '0;
    o_ld_match  = 1'b0;
    o_st_match  = 1'b0;
    for (int i = 0; i < int'(MSHR_NUM); i++) begin
      w_fill_hit[i] = r_entries[i].busy && (i_fill_tag != '0) &&
                      (r_entries[i].tag == i_fill_tag);
      w_free[i]     = !r_entries[i].busy;
      if (w_fill_hit[i])
        o_fill_addr = o_fill_addr | r_entries[i].addr;
      if (r_entries[i].busy && !w_fill_hit[i] && (r_entries[i].addr == i_ld_addr))
        o_ld_match = 1'b1;
      if (r_entries[i].busy && !w_fill_hit[i] && (r_entries[i].addr == i_st_addr))
        o_st_match = 1'b1;
    end
    for (int i = int'(MSHR_NUM) - 1; i >= 0; i--) begin
      if (w_free[i])
        w_alloc_idx = MSHR_IDX_W'(i);
    end
  end

  assign o_fill_vld = |w_fill_hit;
  assign o_full     = ~|w_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MSHR_NUM); i++)
        r_entries[i] <= '0;
    end else begin
      for (int i = 0; i < int'(MSHR_NUM); i++) begin
        if (w_fill_hit[i])
          r_entries[i].busy <= 1'b0;
      end
      if (i_alloc)
        r_entries[w_alloc_idx] <= '{busy: 1'b1, addr: i_alloc_addr, tag: i_alloc_tag};
    end
  end

endmodule

// File: rtl/dcache_mshr_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache with MSHRs.
// Loads hit combinationally; misses go to memory and return as fill broadcasts.
module dcache_mshr_ctrl
  import dcache_mshr_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    ld_addr_i,
  input  logic                 ld_en_i,
  input  logic [ADDR_W-1:0]    st_addr_i,
  input  logic [DATA_W-1:0]    st_data_i,
  input  logic                 st_en_i,
  output logic                 hit_o,
  output logic [DATA_W-1:0]    data_o,
  output logic                 mshr_ld_ack_o,
  output logic                 mshr_st_ack_o,
  output logic                 mshr_vld_o,
  output logic [ADDR_W-1:0]    mshr_addr_o,
  output logic                 mshr_stall_o,
  output logic [1:0]           mem_command_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [DATA_W-1:0]    mem_data_o,
  input  logic [MEM_TAG_W-1:0] mem_response_i,
  input  logic [MEM_TAG_W-1:0] mem_tag_i,
  input  logic [DATA_W-1:0]    mem_data_i
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [DATA_W-1:0]    r_data [NUM_LINES];

  logic                 w_mshr_fill, w_fill_vld, w_ld_match, w_st_match, w_full;
  logic [ADDR_W-1:0]    w_fill_addr;
  logic [IDX_W-1:0]     w_ld_idx, w_st_idx, w_fill_idx;
  logic [TAG_W-1:0]     w_ld_tag, w_st_tag, w_fill_tag;
  logic                 w_ld_hit, w_ld_miss, w_ld_issue, w_resp_ok, w_alloc;
  logic                 w_st_issue, w_st_ack, w_st_upd;

  assign w_ld_idx   = ld_addr_i[3 +: IDX_W];
  assign w_ld_tag   = ld_addr_i[ADDR_W-1 -: TAG_W];
  assign w_st_idx   = st_addr_i[3 +: IDX_W];
  assign w_st_tag   = st_addr_i[ADDR_W-1 -: TAG_W];
  assign w_fill_idx = w_fill_addr[3 +: IDX_W];
  assign w_fill_tag = w_fill_addr[ADDR_W-1 -: TAG_W];

  dcache_mshr_ctrl_mshr_file u_mshr_file (
    .clk          (clk),
    .rst          (rst),
    .i_fill_tag   (mem_tag_i),
    .i_ld_addr    (ld_addr_i),
    .i_st_addr    (st_addr_i),
    .i_alloc      (w_alloc),
    .i_alloc_addr (ld_addr_i),
    .i_alloc_tag  (mem_response_i),
    .o_fill_vld   (w_mshr_fill),
    .o_fill_addr  (w_fill_addr),
    .o_ld_match   (w_ld_match),
    .o_st_match   (w_st_match),
    .o_full       (w_full)
  );

  // Hit, miss handling and memory-port arbitration (load miss beats store).
  always_comb begin
    w_fill_vld = w_mshr_fill && !rst;
    w_resp_ok  = (mem_response_i != '0);
    w_ld_hit   = ld_en_i && r_valid[w_ld_idx] && (r_tag[w_ld_idx] == w_ld_tag) && !w_fill_vld;
    w_ld_miss  = ld_en_i && !w_ld_hit && !rst;
    w_ld_issue = w_ld_miss && !w_ld_match && !w_full;
    w_alloc    = w_ld_issue && w_resp_ok;
    w_st_issue = st_en_i && !w_st_match && !w_ld_issue && !rst;
    w_st_ack   = w_st_issue && w_resp_ok;
    // A same-cycle fill to the store's index replaces the tag, so judge against the fill.
    if (w_fill_vld && (w_fill_idx == w_st_idx))
      w_st_upd = w_st_ack && (w_fill_addr == st_addr_i);
    else
      w_st_upd = w_st_ack && r_valid[w_st_idx] && (r_tag[w_st_idx] == w_st_tag);
  end

  always_comb begin
    hit_o         = 1'b0;
    data_o        = '0;
    mshr_ld_ack_o = 1'b0;
    mshr_st_ack_o = 1'b0;
    mshr_vld_o    = 1'b0;
    mshr_addr_o   = '0;
    mshr_stall_o  = 1'b0;
    mem_command_o = MEM_NONE;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    if (!rst) begin
      mshr_stall_o  = w_full;
      mshr_ld_ack_o = (w_ld_miss && w_ld_match) || w_alloc;
      mshr_st_ack_o = w_st_ack;
      if (w_fill_vld) begin
        mshr_vld_o  = 1'b1;
        mshr_addr_o = w_fill_addr;
        data_o      = mem_data_i;
      end else if (w_ld_hit) begin
        hit_o  = 1'b1;
        data_o = r_data[w_ld_idx];
      end
      if (w_ld_issue) begin
        mem_command_o = MEM_LOAD;
        mem_addr_o    = ld_addr_i;
      end else if (w_st_issue) begin
        mem_command_o = MEM_STORE;
        mem_addr_o    = st_addr_i;
        mem_data_o    = st_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_valid <= '0;
    else if (w_fill_vld)
      r_valid[w_fill_idx] <= 1'b1;
  end

  // Fill writes first; a same-cycle store to the same line is younger and wins.
  always_ff @(posedge clk) begin
    if (w_fill_vld) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_data_i;
    end
    if (w_st_upd)
      r_data[w_st_idx] <= st_data_i;
  end

endmodule
